// File: rtl/conv_mac_5x5_if.sv
// Bus between the window/weight buffers and the 5x5 MAC engine.
// Operand inputs plus the start request, and the busy/out_valid/result status.
interface conv_mac_5x5_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAPS       = 25
);
   // start is a request sampled only while busy is low; operands are captured on that
   // same edge. out_valid is a one-cycle pulse; result holds its value between pulses.
   logic                         start;
   logic [TAPS*DATA_WIDTH-1:0]   window_in;
   logic [TAPS*DATA_WIDTH-1:0]   weights_in;
   logic [DATA_WIDTH-1:0]        bias_in;
   logic                         busy;
   logic                         out_valid;
   logic [DATA_WIDTH-1:0]        result;

   modport master (
      output start, window_in, weights_in, bias_in,
      input  busy, out_valid, result
   );

   modport slave (
      input  start, window_in, weights_in, bias_in,
      output busy, out_valid, result
   );
endinterface

// File: rtl/conv_mac_5x5.sv
// Sequential 5x5 convolution MAC: latches a window, weights and bias, accumulates one tap
// per cycle and emits a saturated fixed-point result.
module conv_mac_5x5 #(
   parameter int DATA_WIDTH  = 32,
   parameter int KERNAL_SIZE = 5,
   parameter int FRAC_BITS   = 16
) (
   input  logic             clk,
   input  logic             reset,
   conv_mac_5x5_if.slave    bus,
   output logic [1:0]       state_dbg
);
   localparam int TAPS  = KERNAL_SIZE * KERNAL_SIZE;
   localparam int ACC_W = 2 * DATA_WIDTH + $clog2(TAPS + 1);
   localparam int CNT_W = $clog2(TAPS);
   localparam int EXT_W = ACC_W - DATA_WIDTH - FRAC_BITS;
   localparam int HI_W  = ACC_W - DATA_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                         state;
   logic [CNT_W-1:0]               cnt;
   logic signed [ACC_W-1:0]        acc;
   logic [TAPS*DATA_WIDTH-1:0]     win_q;
   logic [TAPS*DATA_WIDTH-1:0]     wgt_q;
   logic [DATA_WIDTH-1:0]          result_q;
   logic                           out_valid_q;

   logic signed [DATA_WIDTH-1:0]   pix;
   logic signed [DATA_WIDTH-1:0]   wgt;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]        prod_ext;
   logic signed [ACC_W-1:0]        shifted;
   logic [HI_W-1:0]                upper;
   logic [DATA_WIDTH-1:0]          sat;

   always_comb begin
      pix      = win_q[int'(cnt) * DATA_WIDTH +: DATA_WIDTH];
      wgt      = wgt_q[int'(cnt) * DATA_WIDTH +: DATA_WIDTH];
      prod     = pix * wgt;
      prod_ext = {{(ACC_W - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      shifted  = acc >>> FRAC_BITS;
      // The value fits only if every bit from the result's sign bit upward agrees.
      upper    = shifted[ACC_W-1:DATA_WIDTH-1];
      if ((&upper) || !(|upper))
         sat = shifted[DATA_WIDTH-1:0];
      else if (shifted[ACC_W-1])
         sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         win_q       <= '0;
         wgt_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  win_q <= bus.window_in;
                  wgt_q <= bus.weights_in;
                  cnt   <= '0;
                  // Bias is aligned to the product's 2*FRAC_BITS fractional point.
                  acc   <= {{EXT_W{bus.bias_in[DATA_WIDTH-1]}}, bus.bias_in, {FRAC_BITS{1'b0}}};
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + prod_ext;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(TAPS - 1))
                  state <= FINISH;
            end
            FINISH: begin
               result_q    <= sat;
               out_valid_q <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign state_dbg     = state;
endmodule

// File: tb/tb_conv_mac_5x5.sv
// Self-checking bench for conv_mac_5x5: fixed and random vectors against an
// arbitrary-precision reference sum, plus latch/ignore, back-to-back and reset-abort sequences.
module tb_conv_mac_5x5;
   localparam int DW   = 32;
   localparam int K    = 5;
   localparam int TAPS = K * K;
   localparam int NVEC = 12;

   typedef struct {
      logic [TAPS*DW-1:0] win;
      logic [TAPS*DW-1:0] wgt;
      logic [DW-1:0]      bias;
      logic [DW-1:0]      exp_res;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state_dbg;
   logic [1:0] idle_code;

   int         n_vec  = 0;
   int         n_miss = 0;
   logic [DW-1:0] exp_q[$];
   vec_t       tbl[NVEC];

   always #5 clk = ~clk;

   conv_mac_5x5_if #(.DATA_WIDTH(DW), .TAPS(TAPS)) bus ();

   conv_mac_5x5 #(.DATA_WIDTH(DW), .KERNAL_SIZE(K), .FRAC_BITS(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Reference: exact wide-integer sum, floor shift, clamp to the signed range.
   function automatic logic [DW-1:0] ref_model(input logic [TAPS*DW-1:0] w,
                                               input logic [TAPS*DW-1:0] g,
                                               input logic [DW-1:0] b);
      logic signed [127:0] sum, pe, qe, sh;
      pe  = $signed(b);
      sum = pe * 65536;
      for (int k = 0; k < TAPS; k++) begin
         pe  = $signed(w[k*DW +: DW]);
         qe  = $signed(g[k*DW +: DW]);
         sum = sum + pe * qe;
      end
      sh = sum >>> 16;
      if (sh > 128'sd2147483647) return 32'h7FFFFFFF;
      if (sh < -128'sd2147483648) return 32'h80000000;
      return sh[DW-1:0];
   endfunction

   function automatic logic [TAPS*DW-1:0] all_taps(input logic [DW-1:0] v);
      return {TAPS{v}};
   endfunction

   function automatic logic [TAPS*DW-1:0] one_tap(input logic [DW-1:0] v);
      logic [TAPS*DW-1:0] r;
      r = '0;
      r[DW-1:0] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_word(input int mode);
      if (mode == 0) return $urandom_range(0, 32'h3FFFF) - 32'h20000;
      return $urandom;
   endfunction

   function automatic logic [TAPS*DW-1:0] rand_taps(input int mode);
      logic [TAPS*DW-1:0] r;
      for (int k = 0; k < TAPS; k++) r[k*DW +: DW] = rand_word(mode);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [TAPS*DW-1:0] w, input logic [TAPS*DW-1:0] g,
                        input logic [DW-1:0] b, input logic st);
      bus.window_in  = w;
      bus.weights_in = g;
      bus.bias_in    = b;
      bus.start      = st;
   endtask

   // One start pulse, then watch 41 sample points (k = cycles after the start edge).
   task automatic run_vec(input string name, input vec_t v);
      int pulses, lat, busy_n;
      logic [DW-1:0] got, exp;
      exp_q.push_back(v.exp_res);
      pulses = 0; lat = -1; busy_n = 0; got = '0;
      @(negedge clk);
      drive(v.win, v.wgt, v.bias, 1'b1);
      @(negedge clk);
      drive('0, '0, '0, 1'b0);
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.busy) busy_n++;
         if (bus.out_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               got = bus.result;
            end
         end
      end
      exp = exp_q.pop_front();
      check({name, " result"}, 64'(got), 64'(exp));
      check({name, " latency"}, 64'(lat), 64'd26);
      check({name, " busy cycles"}, 64'(busy_n), 64'd26);
      check({name, " pulses"}, 64'(pulses), 64'd1);
      check({name, " idle state"}, 64'(state_dbg), 64'(idle_code));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, np;
      int pk[3];
      logic [DW-1:0] pr[3];
      vec_t basic;

      // Fixed corner vectors, then random rows priced by the reference model.
      tbl[0] = '{all_taps(32'h00010000), all_taps(32'h00010000), 32'h0, 32'h00190000};
      tbl[1] = '{one_tap(32'hFFFF0000), one_tap(32'h00010000), 32'h00008000, 32'hFFFF8000};
      tbl[2] = '{one_tap(32'hFFFFFFFF), one_tap(32'h00008000), 32'h0, 32'hFFFFFFFF};
      tbl[3] = '{all_taps(32'h7FFF0000), all_taps(32'h7FFF0000), 32'h0, 32'h7FFFFFFF};
      tbl[4] = '{all_taps(32'h7FFF0000), all_taps(32'h80010000), 32'h0, 32'h80000000};
      for (int i = 5; i < NVEC; i++) begin
         tbl[i].win  = rand_taps(i >= 10 ? 1 : 0);
         tbl[i].wgt  = rand_taps(i == 11 ? 1 : 0);
         tbl[i].bias = rand_word(i & 1);
         tbl[i].exp_res = ref_model(tbl[i].win, tbl[i].wgt, tbl[i].bias);
      end
      basic = tbl[0];

      // Clock/reset
      reset = 1'b1;
      drive('0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      idle_code = state_dbg;
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

      // Operands scrambled and start pulsed through MAC and FINISH must not disturb the result.
      @(negedge clk);
      drive(basic.win, basic.wgt, basic.bias, 1'b1);
      pulses = 0; np = 0;
      for (int k = 0; k <= 45; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            pulses++;
            check($sformatf("latch result k=%0d", k), 64'(bus.result), 64'h00190000);
            check("latch pulse time", 64'(k), 64'd26);
         end
         if (k <= 25) drive(rand_taps(1), rand_taps(1), rand_word(1), 1'b1);
         else drive('0, '0, '0, 1'b0);
      end
      check("latch pulses", 64'(pulses), 64'd1);
      check("latch busy after", 64'(bus.busy), 64'd0);

      // Start held high: one acceptance every 27 cycles.
      @(negedge clk);
      drive(basic.win, basic.wgt, basic.bias, 1'b1);
      for (int k = 0; k <= 100; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (np < 3) begin
               pk[np] = k;
               pr[np] = bus.result;
            end
            np++;
         end
      end
      drive('0, '0, '0, 1'b0);
      check("held start pulses", 64'(np), 64'd3);
      if (np >= 3) begin
         check("held first pulse", 64'(pk[0]), 64'd26);
         check("held spacing 1", 64'(pk[1] - pk[0]), 64'd27);
         check("held spacing 2", 64'(pk[2] - pk[1]), 64'd27);
         for (int i = 0; i < 3; i++)
            check($sformatf("held result %0d", i), 64'(pr[i]), 64'h00190000);
      end
      repeat (40) @(negedge clk);

      // Reset ten cycles into a computation aborts it silently.
      drive(tbl[3].win, tbl[3].wgt, tbl[3].bias, 1'b1);
      @(negedge clk);
      drive('0, '0, '0, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      check("abort pulses", 64'(pulses), 64'd0);
      check("abort result", 64'(bus.result), 64'd0);
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort state", 64'(state_dbg), 64'(idle_code));
      run_vec("after abort", basic);
      run_vec("after abort neg", tbl[4]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
